branch_unit: RTL and testbench
==============================

# branch_unit

Decode-side branch resolver for the 16-bit core: latches each `pc`/`inst` pair presented by the fetch stage and decodes the control-flow opcodes BR/JMP/CALL/RET. It drives the fetch stage's `br`/`br_pc` redirect inputs and squashes the one wrong-path instruction fetched behind a taken branch. CALL/RET use an internal return-address stack (RAS). Non-control instructions pass through to the decode/execute path with a valid flag.

## Interface
- `RAS_DEPTH`, 8: number of RAS entries; power of two, minimum 2.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `if_pc` in 16: pc currently driven by the fetch stage.
- `if_inst` in 16: instruction at `if_pc`.
- `zf`, `nf`, `cf` in 1 each: ALU flags, sampled combinationally while the instruction is in this stage.
- `br` out 1: redirect request to fetch; fetch loads `br_pc` at the next edge.
- `br_pc` out 16: redirect target.
- `id_valid` out 1: the latched instruction is architecturally live.
- `id_pc` out 16: latched pc.
- `id_inst` out 16: latched instruction.
- `ras_ovf` out 1: sticky; set by a push to a full RAS.
- `ras_udf` out 1: one-cycle pulse on RET with an empty RAS.

## Operation
- **Stage register:** on every edge, capture `if_pc`/`if_inst` into `id_pc`/`id_inst`. `id_valid` is loaded with `~br`, so the instruction fetched behind a taken redirect is squashed.
- **Opcode field:** `op = id_inst[15:11]`. JMP = 5'b11000, BR = 5'b11001, CALL = 5'b11010, RET = 5'b11011. All other opcodes are non-control.
- **JMP:** `br = 1`, `br_pc = {id_pc[15:11], id_inst[10:0]}`.
- **CALL:** same target as JMP; push `id_pc + 1` (mod 2^16).
- **BR:** condition `id_inst[10:8]`:
  - 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 !C, 111 never.
  - If the condition is true: `br = 1`, `br_pc = id_pc + sext(id_inst[7:0])`, 16-bit wrap-around.
  - Not taken: `br = 0`.
- **RET:** if the RAS is non-empty, `br = 1`, `br_pc = top`, and the entry is popped. If the RAS is empty, `br = 0`, `ras_udf = 1` for that cycle, and the stack is unchanged.
- **Gating:** all decode actions (`br`, push, pop, `ras_udf`) require `id_valid = 1`. When `id_valid = 0`, `br = 0` and the RAS is untouched.
- **RAS structure:** circular buffer with write pointer `sp` and occupancy `cnt` (0..`RAS_DEPTH`).
  - Push: `mem[sp] <= val`, `sp++`, `cnt = min(cnt + 1, RAS_DEPTH)`.
  - Pop: `sp--`, `cnt--`.
  - Push with `cnt == RAS_DEPTH` overwrites the oldest entry and sets `ras_ovf`.
- **Simultaneous push/pop:** cannot occur; only one instruction is resolved per cycle.
- `br_pc` is a don't-care when `br = 0`; it is driven to 16'h0000 in that case.

## Timing
- **Reset** (`rst` high at an edge):
  - `id_valid = 0`, `id_pc = 0`, `id_inst = 0`, `sp = 0`, `cnt = 0`, `ras_ovf = 0`.
  - Consequently `br = 0`, `br_pc = 0`, `ras_udf = 0`.
  - Reset mid-program discards RAS contents; the next edge after release captures fetch normally.
- **Latency:**
  - Instruction presented in cycle n is latched at the end of cycle n.
  - `br`/`br_pc` are valid combinationally in cycle n+1.
  - Fetch redirects at the end of cycle n+1.
- **Branch penalty:** taken branch costs exactly one bubble. The instruction latched at the end of cycle n+1 has `id_valid = 0`.
- **Back-to-back control instructions:** a branch target that is itself a branch is resolved normally one cycle after it is latched.
- **Flag sampling:** flags are sampled in the same cycle as `br` evaluation; no flag registering in this block.
- **Register updates:** RAS and `ras_ovf` update on the edge ending the cycle in which CALL/RET is resolved.

## Configuration
- **`BRU_RAS_EN`**
  - **Defined:** RAS implemented as above.
  - **Undefined:** no RAS storage. CALL behaves exactly as JMP (no push). RET is non-control (`br = 0`). `ras_ovf` and `ras_udf` are tied 0.

## Test plan
- **Reset:** hold `rst` 2 cycles, then feed `if_pc = 16'h0000`, `if_inst = 16'h0000` -> all outputs 0 during reset; `id_valid = 1` one edge after release; `br = 0`.
- **JMP:** latch `if_pc = 16'h1234`, `if_inst = {5'b11000, 11'h055}` -> next cycle `br = 1`, `br_pc = 16'h1055`. The following latched instruction has `id_valid = 0`.
- **BR negative offset:**
  - `id_pc = 16'h0002`, `inst = {5'b11001, 3'b001, 8'hFC}`, `zf = 1` -> `br = 1`, `br_pc = 16'hFFFE` (wrap).
  - Same instruction with `zf = 0` -> `br = 0`, next `id_valid = 1`.
- **CALL/RET:** CALL at pc 16'h0100 target 0x200 -> `br_pc = 16'h0200`. Later RET -> `br_pc = 16'h0101`. A second RET -> `br = 0`, `ras_udf` pulses one cycle.
- **RAS overflow:** 9 CALLs from pcs 0x10..0x18 with `RAS_DEPTH = 8` -> `ras_ovf = 1` after the 9th. 8 RETs return 0x19..0x12; the 9th RET raises `ras_udf`.
- **Squashed slot and mid-program reset:**
  - CALL in the squashed slot behind a JMP -> no push (a subsequent RET raises `ras_udf`).
  - Assert `rst` with 3 entries stacked -> RET after release raises `ras_udf`; `ras_ovf` is cleared.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit: decode-side resolver for JMP/BR/CALL/RET; the return-address stack is built only when BRU_RAS_EN is defined
module branch_unit #(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] if_pc,
  input  logic [15:0] if_inst,
  input  logic        zf,
  input  logic        nf,
  input  logic        cf,
  output logic        br,
  output logic [15:0] br_pc,
  output logic        id_valid,
  output logic [15:0] id_pc,
  output logic [15:0] id_inst,
  output logic        ras_ovf,
  output logic        ras_udf
);
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_BR   = 5'b11001;
  localparam logic [4:0] OP_CALL = 5'b11010;
  logic [4:0]  op;
  logic [2:0]  cc;
  logic        cond, is_jmp, is_br, ras_pop;
  logic [15:0] ras_top;
  assign op = id_inst[15:11];
  assign cc = id_inst[10:8];
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two and at least 2");
  end
  // Stage register; the slot fetched behind a taken redirect is squashed
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= 16'h0000;
      id_inst  <= 16'h0000;
    end else begin
      id_valid <= ~br;
      id_pc    <= if_pc;
      id_inst  <= if_inst;
    end
  end
  // Condition evaluation and redirect selection; JMP and CALL share a target form
  always_comb begin
    cond   = cc == 3'd0 ? 1'b1 : cc == 3'd1 ? zf : cc == 3'd2 ? ~zf : cc == 3'd3 ? nf :
             cc == 3'd4 ? ~nf : cc == 3'd5 ? cf : cc == 3'd6 ? ~cf : 1'b0;
    is_jmp = id_valid && (op == OP_JMP || op == OP_CALL);
    is_br  = id_valid && op == OP_BR && cond;
    br     = is_jmp | is_br | ras_pop;
    br_pc  = is_jmp ? {id_pc[15:11], id_inst[10:0]} :
             is_br ? id_pc + {{8{id_inst[7]}}, id_inst[7:0]} :
             ras_pop ? ras_top : 16'h0000;
  end
`ifdef BRU_RAS_EN
  localparam logic [4:0] OP_RET = 5'b11011;
  localparam int AW = $clog2(RAS_DEPTH);
  logic [15:0]   mem [RAS_DEPTH];
  logic [AW-1:0] sp;
  logic [AW:0]   cnt;
  logic          is_call, is_ret, full;
  assign is_call = id_valid && op == OP_CALL;
  assign is_ret  = id_valid && op == OP_RET;
  assign full    = cnt == (AW+1)'(RAS_DEPTH);
  assign ras_pop = is_ret && cnt != '0;
  assign ras_udf = is_ret && cnt == '0;
  assign ras_top = mem[sp - 1'b1];
  // Circular stack: a push when full overwrites the oldest entry and flags overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      sp      <= '0;
      cnt     <= '0;
      ras_ovf <= 1'b0;
    end else if (is_call) begin
      mem[sp] <= id_pc + 16'd1;
      sp      <= sp + 1'b1;
      cnt     <= full ? cnt : cnt + 1'b1;
      ras_ovf <= ras_ovf | full;
    end else if (ras_pop) begin
      sp  <= sp - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
`else
  assign ras_pop = 1'b0;
  assign ras_top = 16'h0000;
  assign ras_ovf = 1'b0;
  assign ras_udf = 1'b0;
`endif
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed self-checking bench for branch_unit
module tb_branch_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] if_pc = 16'h0000, if_inst = 16'h0000;
  logic        zf = 1'b0, nf = 1'b0, cf = 1'b0;
  logic        br, id_valid, ras_ovf, ras_udf;
  logic [15:0] br_pc, id_pc, id_inst;
  int total = 0, bad = 0;

  branch_unit #(.RAS_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst),
    .zf(zf), .nf(nf), .cf(cf), .br(br), .br_pc(br_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .ras_ovf(ras_ovf), .ras_udf(ras_udf)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [15:0] pc, input logic [15:0] inst);
    if_pc = pc;
    if_inst = inst;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(16'h0000, 16'h0000);
    tick(16'h0000, 16'h0000);
    chk("rst_valid", {15'd0, id_valid}, 16'd0);
    chk("rst_pc", id_pc, 16'h0000);
    chk("rst_inst", id_inst, 16'h0000);
    chk("rst_br", {15'd0, br}, 16'd0);
    chk("rst_brpc", br_pc, 16'h0000);
    chk("rst_ovf", {15'd0, ras_ovf}, 16'd0);
    chk("rst_udf", {15'd0, ras_udf}, 16'd0);
    rst = 1'b0;
    tick(16'h0000, 16'h0000);
    chk("post_rst_valid", {15'd0, id_valid}, 16'd1);
    chk("post_rst_br", {15'd0, br}, 16'd0);
    // JMP
    tick(16'h1234, 16'hC055);
    chk("jmp_br", {15'd0, br}, 16'd1);
    chk("jmp_pc", br_pc, 16'h1055);
    tick(16'h1235, 16'h0000);
    chk("jmp_squash", {15'd0, id_valid}, 16'd0);
    chk("squash_br", {15'd0, br}, 16'd0);
    // BR Z, offset -4, wraps below zero
    zf = 1'b1;
    tick(16'h0002, 16'hC9FC);
    chk("brz_valid", {15'd0, id_valid}, 16'd1);
    chk("brz_br", {15'd0, br}, 16'd1);
    chk("brz_pc", br_pc, 16'hFFFE);
    zf = 1'b0;
    #1;
    chk("brz_nt_br", {15'd0, br}, 16'd0);
    chk("brz_nt_pc", br_pc, 16'h0000);
    tick(16'h0003, 16'h0000);
    chk("brz_nt_next", {15'd0, id_valid}, 16'd1);
    // BR never
    tick(16'h0010, 16'hCF05);
    chk("brnever", {15'd0, br}, 16'd0);
    // BR !N taken, positive offset
    tick(16'h0020, 16'hCC10);
    chk("brnn_br", {15'd0, br}, 16'd1);
    chk("brnn_pc", br_pc, 16'h0030);
    tick(16'h0030, 16'h0000);
    // BR C not taken, then !C taken with wrap past FFFF
    tick(16'h0040, 16'hCD01);
    chk("brc_nt", {15'd0, br}, 16'd0);
    tick(16'hFFF0, 16'hCE20);
    chk("brnc_pc", br_pc, 16'h0010);
    tick(16'h0010, 16'h0000);
    // CALL
    tick(16'h0100, 16'hD200);
    chk("call_br", {15'd0, br}, 16'd1);
    chk("call_pc", br_pc, 16'h0200);
    tick(16'h0200, 16'h0000);
    chk("call_squash", {15'd0, id_valid}, 16'd0);
`ifdef BRU_RAS_EN
    tick(16'h0201, 16'hD800);
    chk("ret_br", {15'd0, br}, 16'd1);
    chk("ret_pc", br_pc, 16'h0101);
    chk("ret_udf0", {15'd0, ras_udf}, 16'd0);
    tick(16'h0101, 16'h0000);
    tick(16'h0102, 16'hD800);
    chk("ret2_br", {15'd0, br}, 16'd0);
    chk("ret2_udf", {15'd0, ras_udf}, 16'd1);
    tick(16'h0103, 16'h0000);
    chk("udf_pulse", {15'd0, ras_udf}, 16'd0);
    // Overflow: 9 CALLs from 0x10..0x18 into an 8-deep stack
    for (int i = 0; i < 9; i++) begin
      tick(16'h0010 + 16'(i), 16'hD400);
      chk("ovf_call_br", {15'd0, br}, 16'd1);
      if (i == 8) chk("ovf_before", {15'd0, ras_ovf}, 16'd0);
      tick(16'h0400, 16'h0000);
    end
    chk("ovf_set", {15'd0, ras_ovf}, 16'd1);
    for (int i = 0; i < 8; i++) begin
      tick(16'h0500, 16'hD800);
      chk("ovf_ret_pc", br_pc, 16'h0019 - 16'(i));
      tick(16'h0501, 16'h0000);
    end
    tick(16'h0502, 16'hD800);
    chk("ovf_ret9_br", {15'd0, br}, 16'd0);
    chk("ovf_ret9_udf", {15'd0, ras_udf}, 16'd1);
    chk("ovf_sticky", {15'd0, ras_ovf}, 16'd1);
    // CALL in the squashed slot must not push
    tick(16'h0300, 16'hC000);
    chk("sq_jmp", {15'd0, br}, 16'd1);
    tick(16'h0301, 16'hD400);
    chk("sq_call_valid", {15'd0, id_valid}, 16'd0);
    chk("sq_call_br", {15'd0, br}, 16'd0);
    tick(16'h0302, 16'hD800);
    chk("sq_ret_udf", {15'd0, ras_udf}, 16'd1);
    // Mid-program reset discards stacked entries and clears overflow
    for (int i = 0; i < 3; i++) begin
      tick(16'h0600 + 16'(i), 16'hD400);
      tick(16'h0400, 16'h0000);
    end
    rst = 1'b1;
    tick(16'h0000, 16'h0000);
    chk("mrst_ovf", {15'd0, ras_ovf}, 16'd0);
    chk("mrst_valid", {15'd0, id_valid}, 16'd0);
    rst = 1'b0;
    tick(16'h0050, 16'hD800);
    chk("mrst_ret_valid", {15'd0, id_valid}, 16'd1);
    chk("mrst_ret_br", {15'd0, br}, 16'd0);
    chk("mrst_ret_udf", {15'd0, ras_udf}, 16'd1);
`else
    tick(16'h0201, 16'hD800);
    chk("ret_nc_valid", {15'd0, id_valid}, 16'd1);
    chk("ret_nc_br", {15'd0, br}, 16'd0);
    chk("ret_nc_udf", {15'd0, ras_udf}, 16'd0);
    for (int i = 0; i < 9; i++) begin
      tick(16'h0010 + 16'(i), 16'hD400);
      chk("call_jmp_pc", br_pc, 16'h0400);
      tick(16'h0400, 16'h0000);
    end
    chk("ovf_tied", {15'd0, ras_ovf}, 16'd0);
    tick(16'h0500, 16'hD800);
    chk("ret_nc2_br", {15'd0, br}, 16'd0);
    chk("udf_tied", {15'd0, ras_udf}, 16'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
